// File: rtl/round_judge_pkg.sv
// Shared types and helpers for the round_judge match controller.
// Holds the state encoding, parameter defaults and the beats rule.
package round_judge_pkg;

  localparam int DEF_NUM_CHOICES = 3;
  localparam int DEF_SCORE_W     = 4;
  localparam int DEF_WIN_SCORE   = 3;
  localparam int IDX_W           = 4;  // wide enough for up to 15 choices

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_JUDGE,
    ST_SHOW,
    ST_OVER
  } state_e;

  // a beats b when the forward distance (a - b) mod n is in the first half of the ring
  function automatic logic beats(input int a, input int b, input int n);
    int d;
    d = (a - b + n) % n;
    return (d >= 1) && (d <= (n - 1) / 2);
  endfunction

endpackage

// File: rtl/onehot_to_index.sv
// Converts a one-hot choice vector into a binary index plus a one-hot-valid flag.
module onehot_to_index
  import round_judge_pkg::*;
#(
  parameter int N = DEF_NUM_CHOICES
) (
  input  logic [N-1:0]     i_onehot,
  output logic [IDX_W-1:0] o_index,
  output logic             o_valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
    o_index = '0;
    for (int i = 0; i < N; i++) begin
      if (i_onehot[i]) o_index = o_index | IDX_W'(i);
    end
    o_valid = $onehot(i_onehot);
  end

endmodule

// File: rtl/round_judge.sv
// Judges rock-paper-scissors style rounds between two players and keeps score
// until one player reaches WIN_SCORE.
module round_judge
  import round_judge_pkg::*;
#(
  parameter int NUM_CHOICES = DEF_NUM_CHOICES,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int WIN_SCORE   = DEF_WIN_SCORE
) (
  input  logic                               clk,
  input  logic                               stateReset,
  input  logic [NUM_CHOICES-1:0]             p1Choice,
  input  logic [NUM_CHOICES-1:0]             p2Choice,
  input  logic                               roundValid,
  output logic                               roundReady,
  input  logic                               resultAck,
  output logic                               resultValid,
  output logic [NUM_CHOICES*NUM_CHOICES-1:0] scenario,
  output logic                               winner1,
  output logic                               winner2,
  output logic                               tie,
  output logic                               invalid,
  output logic [SCORE_W-1:0]                 player1,
  output logic [SCORE_W-1:0]                 player2,
  output logic                               matchOver
);

  localparam int                 SCEN_W = NUM_CHOICES * NUM_CHOICES;
  localparam logic [SCORE_W-1:0] WIN    = SCORE_W'(WIN_SCORE);

  state_e                  r_state;
  state_e                  w_next;
  logic [NUM_CHOICES-1:0]  r_p1;
  logic [NUM_CHOICES-1:0]  r_p2;
  logic [SCEN_W-1:0]       r_scenario;
  logic                    r_winner1;
  logic                    r_winner2;
  logic                    r_tie;
  logic                    r_invalid;
  logic [SCORE_W-1:0]      r_score1;
  logic [SCORE_W-1:0]      r_score2;

  logic [IDX_W-1:0]        w_idx1;
  logic [IDX_W-1:0]        w_idx2;
  logic                    w_val1;
  logic                    w_val2;
  logic                    w_valid;
  logic                    w_p1_beats;
  logic                    w_p2_beats;
  logic [SCEN_W-1:0]       w_scen_next;

  onehot_to_index #(.N(NUM_CHOICES)) u_enc_p1 (
    .i_onehot (r_p1),
    .o_index  (w_idx1),
    .o_valid  (w_val1)
  );

  onehot_to_index #(.N(NUM_CHOICES)) u_enc_p2 (
    .i_onehot (r_p2),
    .o_index  (w_idx2),
    .o_valid  (w_val2)
  );

  assign w_valid    = w_val1 & w_val2;
  assign w_p1_beats = beats(int'(w_idx1), int'(w_idx2), NUM_CHOICES);
  assign w_p2_beats = beats(int'(w_idx2), int'(w_idx1), NUM_CHOICES);

  // Malformed rounds collapse onto bit 0 of the scenario code.
  always_comb begin
    w_scen_next = SCEN_W'(1);
    if (w_valid) w_scen_next = SCEN_W'(1) << (int'(w_idx1) * NUM_CHOICES + int'(w_idx2));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (stateReset) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (roundValid) w_next = ST_JUDGE;
      ST_JUDGE: w_next = ST_SHOW;
      ST_SHOW:  if (resultAck) w_next = (r_score1 == WIN || r_score2 == WIN) ? ST_OVER : ST_IDLE;
      ST_OVER:  w_next = ST_OVER;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (stateReset) begin
      r_p1 <= '0;
      r_p2 <= '0;
    end else if (r_state == ST_IDLE && roundValid) begin
      r_p1 <= p1Choice;
      r_p2 <= p2Choice;
    end
  end

  always_ff @(posedge clk) begin
    if (stateReset) begin
      r_scenario <= '0;
      r_winner1  <= 1'b0;
      r_winner2  <= 1'b0;
      r_tie      <= 1'b0;
      r_invalid  <= 1'b0;
      r_score1   <= '0;
      r_score2   <= '0;
    end else if (r_state == ST_JUDGE) begin
      r_scenario <= w_scen_next;
      r_invalid  <= ~w_valid;
      r_winner1  <= w_valid & w_p1_beats;
      r_winner2  <= w_valid & w_p2_beats;
      r_tie      <= ~w_valid | (~w_p1_beats & ~w_p2_beats);
      if (w_valid && w_p1_beats && r_score1 < WIN) r_score1 <= r_score1 + 1'b1;
      if (w_valid && w_p2_beats && r_score2 < WIN) r_score2 <= r_score2 + 1'b1;
    end
  end

  assign roundReady  = (r_state == ST_IDLE);
  assign resultValid = (r_state == ST_SHOW);
  assign matchOver   = (r_state == ST_OVER);
  assign scenario    = r_scenario;
  assign winner1     = r_winner1;
  assign winner2     = r_winner2;
  assign tie         = r_tie;
  assign invalid     = r_invalid;
  assign player1     = r_score1;
  assign player2     = r_score2;

endmodule

// File: tb/tb_round_judge.sv
// Self-checking bench for round_judge: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural match model.
module tb_round_judge;

  localparam int N   = 3;
  localparam int SW  = 4;
  localparam int WIN = 3;

  logic          clk = 1'b0;
  logic          stateReset = 1'b1;
  logic          roundValid = 1'b0;
  logic          resultAck  = 1'b0;
  logic [N-1:0]  p1Choice   = '0;
  logic [N-1:0]  p2Choice   = '0;
  logic          roundReady, resultValid, winner1, winner2, tie, invalid, matchOver;
  logic [N*N-1:0] scenario;
  logic [SW-1:0] player1, player2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  round_judge #(.NUM_CHOICES(N), .SCORE_W(SW), .WIN_SCORE(WIN)) dut (
    .clk         (clk),
    .stateReset  (stateReset),
    .p1Choice    (p1Choice),
    .p2Choice    (p2Choice),
    .roundValid  (roundValid),
    .roundReady  (roundReady),
    .resultAck   (resultAck),
    .resultValid (resultValid),
    .scenario    (scenario),
    .winner1     (winner1),
    .winner2     (winner2),
    .tie         (tie),
    .invalid     (invalid),
    .player1     (player1),
    .player2     (player2),
    .matchOver   (matchOver)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 waiting, 1 judging, 2 showing, 3 match finished.
  int            m_phase = 0;
  logic [N-1:0]  m_a = '0, m_b = '0;
  logic [N*N-1:0] m_scen = '0;
  logic          m_w1 = 0, m_w2 = 0, m_tie = 0, m_inv = 0;
  int            m_s1 = 0, m_s2 = 0;

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_judge();
    int ia, ib, d;
    if ($countones(m_a) != 1 || $countones(m_b) != 1) begin
      m_inv = 1; m_tie = 1; m_w1 = 0; m_w2 = 0; m_scen = 1;
    end else begin
      ia = idx_of(m_a);
      ib = idx_of(m_b);
      d  = ((ia - ib) % N + N) % N;
      m_inv  = 0;
      m_tie  = (d == 0);
      m_w1   = (d != 0) && (d <= (N - 1) / 2);
      m_w2   = (d != 0) && !m_w1;
      m_scen = (N*N)'(1) << (ia * N + ib);
      if (m_w1 && m_s1 < WIN) m_s1++;
      if (m_w2 && m_s2 < WIN) m_s2++;
    end
  endtask

  always @(posedge clk) begin
    if (stateReset) begin
      m_phase = 0; m_a = '0; m_b = '0; m_scen = '0;
      m_w1 = 0; m_w2 = 0; m_tie = 0; m_inv = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      case (m_phase)
        0: if (roundValid) begin m_a = p1Choice; m_b = p2Choice; m_phase = 1; end
        1: begin model_judge(); m_phase = 2; end
        2: if (resultAck) m_phase = (m_s1 == WIN || m_s2 == WIN) ? 3 : 0;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    check("m_roundReady",  32'(roundReady),  32'(m_phase == 0));
    check("m_resultValid", 32'(resultValid), 32'(m_phase == 2));
    check("m_matchOver",   32'(matchOver),   32'(m_phase == 3));
    check("m_scenario",    32'(scenario),    32'(m_scen));
    check("m_flags",       {28'd0, winner1, winner2, tie, invalid}, {28'd0, m_w1, m_w2, m_tie, m_inv});
    check("m_player1",     32'(player1),     32'(m_s1));
    check("m_player2",     32'(player2),     32'(m_s2));
  end

  task automatic cyc(input logic rst, input logic rv, input logic ack,
                     input logic [N-1:0] a, input logic [N-1:0] b);
    stateReset = rst; roundValid = rv; resultAck = ack; p1Choice = a; p2Choice = b;
    @(posedge clk);
    #1;
  endtask

  task automatic play(input logic [N-1:0] a, input logic [N-1:0] b);
    cyc(0, 1, 0, a, b);
    cyc(0, 0, 0, a, b);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    cyc(1, 0, 0, '0, '0);
    check("rst_ready",  32'(roundReady),  1);
    check("rst_valid",  32'(resultValid), 0);
    check("rst_over",   32'(matchOver),   0);
    check("rst_scen",   32'(scenario),    0);
    cyc(0, 0, 0, '0, '0);

    play(3'b010, 3'b001);
    check("r1_valid",   32'(resultValid), 1);
    check("r1_win1",    32'(winner1),     1);
    check("r1_scen",    32'(scenario),    32'h8);
    check("r1_p1",      32'(player1),     1);
    check("r1_p2",      32'(player2),     0);
    cyc(0, 0, 1, '0, '0);
    check("r1_ack_idle", 32'(roundReady), 1);

    play(3'b100, 3'b100);
    check("tie_flag",   32'(tie),         1);
    check("tie_scen",   32'(scenario),    32'h100);
    check("tie_p1",     32'(player1),     1);
    cyc(0, 0, 1, '0, '0);

    play(3'b011, 3'b001);
    check("inv_flag",   {30'd0, invalid, tie}, 32'h3);
    check("inv_scen",   32'(scenario),    1);
    check("inv_scores", {player1, player2}, 32'h10);
    cyc(0, 0, 1, '0, '0);

    // roundValid held through SHOW and coincident with the ack
    cyc(0, 1, 0, 3'b001, 3'b010);
    cyc(0, 1, 0, 3'b001, 3'b010);
    cyc(0, 1, 0, 3'b001, 3'b010);
    cyc(0, 1, 1, 3'b001, 3'b010);
    check("hold_idle",  32'(roundReady),  1);
    check("hold_p2",    32'(player2),     1);
    cyc(0, 0, 0, '0, '0);

    for (int k = 0; k < 2; k++) begin
      play(3'b001, 3'b010);
      cyc(0, 0, 1, '0, '0);
    end
    check("over_flag",  32'(matchOver),   1);
    check("over_ready", 32'(roundReady),  0);
    check("over_p2",    32'(player2),     3);
    cyc(0, 1, 0, 3'b010, 3'b001);
    cyc(0, 1, 1, 3'b010, 3'b001);
    cyc(0, 0, 1, '0, '0);
    check("over_stuck", 32'(matchOver),   1);
    check("over_p1",    32'(player1),     1);

    cyc(1, 0, 0, '0, '0);
    cyc(0, 0, 0, '0, '0);
    play(3'b010, 3'b001);
    cyc(0, 0, 1, '0, '0);
    play(3'b100, 3'b010);
    check("mid_p1",     32'(player1),     2);
    cyc(1, 1, 1, 3'b010, 3'b001);
    check("mid_ready",  32'(roundReady),  1);
    check("mid_p1_rst", 32'(player1),     0);
    check("mid_valid",  32'(resultValid), 0);
    check("mid_scen",   32'(scenario),    0);

    for (int k = 0; k < 3000; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'(1 << $urandom_range(0, 2));
      rb = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'(1 << $urandom_range(0, 2));
      cyc(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0), ra, rb);
    end
    cyc(0, 0, 0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
